// File: rtl/busy_arbiter_if.sv
// busy_arbiter_if: client-side handshake bundle for busy_arbiter.
//   req_1..req_4        client k requests the shared memory port (level)
//   done_1..done_4      client k has finished (pulse or level)
//   busy_1..busy_4      one-hot ownership grant to the port distributor
//   grant_id[1:0]       index of the current or last owner (0..3)
//   idle                arbiter is in IDLE
//   timeout_err         one-cycle pulse on a forced release
//   err_cnt[7:0]        saturating count of forced releases
// Modports: master = client/requester side, slave = arbiter side.
interface busy_arbiter_if;
    logic       req_1, req_2, req_3, req_4;
    logic       done_1, done_2, done_3, done_4;
    logic       busy_1, busy_2, busy_3, busy_4;
    logic [1:0] grant_id;
    logic       idle;
    logic       timeout_err;
    logic [7:0] err_cnt;

    modport master (
        output req_1, req_2, req_3, req_4,
        output done_1, done_2, done_3, done_4,
        input  busy_1, busy_2, busy_3, busy_4,
        input  grant_id, idle, timeout_err, err_cnt
    );

    modport slave (
        input  req_1, req_2, req_3, req_4,
        input  done_1, done_2, done_3, done_4,
        output busy_1, busy_2, busy_3, busy_4,
        output grant_id, idle, timeout_err, err_cnt
    );
endinterface

// File: rtl/busy_arbiter.sv
// busy_arbiter: round-robin owner selection for the shared old-word/new-word
// memory port. Drives the distributor's one-hot busy inputs, inserts a drain
// gap between owners and force-releases any owner holding past TIMEOUT cycles.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    busy_arbiter_if.slave (req/done in; busy, grant_id, idle,
//          timeout_err, err_cnt out -- all registered)
// Parameters:
//   GAP_CYCLES  all-busy-low cycles in GAP before returning to IDLE (1..15)
//   TIMEOUT     maximum hold length in cycles (2..1023)
module busy_arbiter #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1023
) (
    input logic           clk,
    input logic           reset,
    busy_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_e;

    localparam logic [9:0] HOLD_LAST = 10'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] busy_q, busy_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic       idle_q, idle_d;
    logic       timeout_err_q, timeout_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [9:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    logic [3:0] req_v, done_v;
    logic [1:0] sel, idx;
    logic       found;
    logic       rel;

    assign req_v  = {bus.req_4, bus.req_3, bus.req_2, bus.req_1};
    assign done_v = {bus.done_4, bus.done_3, bus.done_2, bus.done_1};

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        grant_id_d    = grant_id_q;
        idle_d        = idle_q;
        timeout_err_d = 1'b0;
        err_cnt_d     = err_cnt_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        sel           = ptr_q;
        idx           = ptr_q;
        found         = 1'b0;
        rel           = 1'b0;

        // First requester at or above the pointer, wrapping 3 -> 0.
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req_v[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    busy_d     = 4'b0001 << sel;
                    grant_id_d = sel;
                    ptr_d      = sel + 2'd1;
                    hold_cnt_d = '0;
                    idle_d     = 1'b0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + 10'd1;
                rel        = done_v[grant_id_q] | ~req_v[grant_id_q];
                // A release on the last allowed cycle wins over the timeout.
                if (rel || hold_cnt_q == HOLD_LAST) begin
                    busy_d    = '0;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                    if (!rel) begin
                        timeout_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF)
                            err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                    idle_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                busy_d  = '0;
                idle_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            busy_q        <= '0;
            grant_id_q    <= '0;
            idle_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            err_cnt_q     <= '0;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            idle_q        <= idle_d;
            timeout_err_q <= timeout_err_d;
            err_cnt_q     <= err_cnt_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign bus.busy_1      = busy_q[0];
    assign bus.busy_2      = busy_q[1];
    assign bus.busy_3      = busy_q[2];
    assign bus.busy_4      = busy_q[3];
    assign bus.grant_id    = grant_id_q;
    assign bus.idle        = idle_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: doc/busy_arbiter.md
# busy_arbiter

Round-robin arbiter that decides which of four memory clients owns the shared old-word/new-word memory port. It sits directly upstream of the port distributor: its one-hot `busy_1..busy_4` outputs drive the distributor's busy inputs. It guarantees that at most one busy is high at any time. It inserts a drain gap between owners so the distributor's registered mux never forwards a stale write from the previous owner. It also bounds each ownership period with a timeout.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: cycles with all busy low between release and the next arbitration. Legal range 1..15.
- `TIMEOUT`, default 1023: maximum cycles a client may hold the port. Legal range 2..1023.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_1..req_4`  in  1  client k requests the port (level; held until done).
- `done_1..done_4`  in  1  client k finished (pulse or level). Sampled only while client k is granted.
- `busy_1..busy_4`  out  1  one-hot grant to the distributor; all low when no owner.
- `grant_id`  out  2  index of the current or last owner (0..3 = client 1..4).
- `idle`  out  1  high only in state IDLE.
- `timeout_err`  out  1  one-cycle pulse when a hold is force-released.
- `err_cnt`  out  8  count of timeouts; saturates at 255.

## Operation
- States: IDLE, HOLD, GAP. All outputs are registered.
- Reset (the cycle after `reset` is sampled high):
  - state=IDLE, busy_1..4=0, grant_id=0, idle=1, timeout_err=0, err_cnt=0.
  - Priority pointer = 0 (client 1 first). Hold counter and gap counter = 0.
  - A reset asserted mid-HOLD drops busy on the next edge without any gap.
- IDLE:
  - If any req is high, select the first requester scanning from the pointer upward, wrapping 3→0.
  - Set busy for the selected client, set grant_id, set pointer = selected+1 mod 4, clear the hold counter, go to HOLD.
  - With no requests, stay in IDLE.
- HOLD:
  - The hold counter increments every cycle.
  - Release condition: done_g=1 or req_g=0 for the granted client g.
  - Timeout condition: counter = TIMEOUT-1 with no release.
  - On either condition: clear busy, load the gap counter with GAP_CYCLES-1, go to GAP.
  - On timeout only: pulse timeout_err and increment err_cnt (saturating).
  - Release and timeout in the same cycle count as a normal release: no error.
  - Requests and done from non-granted clients are ignored.
- GAP:
  - All busy low. Count down; at 0 go to IDLE.
  - Requests arriving during GAP are serviced in IDLE under the updated pointer.
- Invariants:
  - busy_1..4 is one-hot or zero in every cycle.
  - grant_id holds its value through GAP and IDLE.

## Timing
- Grant latency: a req sampled at edge N in IDLE gives busy high after edge N. idle drops at the same edge.
- Release latency: done sampled at edge M gives busy low after edge M.
- Owner-to-owner spacing: busy is all-zero for GAP_CYCLES+1 cycles (GAP plus one IDLE cycle). This exceeds the distributor's one-register latency.
- Maximum hold: busy stays high for exactly TIMEOUT cycles, and timeout_err coincides with the first busy-low cycle.
- Fairness: with all four requesting continuously, grants rotate 1,2,3,4,1…; a requester waits at most 3 ownership periods.

## Test plan
- Reset, then req_3=1 at cycle 5 → busy_3=1 from cycle 6, grant_id=2, idle=0. done_3 pulse at cycle 10 → busy_3=0 from cycle 11, idle=1 from cycle 13 (GAP_CYCLES=2).
- req_1..4 all held high, each client pulses done 3 cycles after its grant → grant order 1,2,3,4,1. At least 3 all-zero busy cycles between grants. busy is never two-hot (check every cycle).
- req_2 held, done never asserted, TIMEOUT=8 → busy_2 high exactly 8 cycles. timeout_err=1 for one cycle, err_cnt=1. After the gap, busy_2 is re-granted because it is the only requester.
- TIMEOUT=8, done_2 asserted on the 8th hold cycle → normal release, timeout_err stays 0, err_cnt unchanged.
- reset asserted during HOLD of client 4 → busy_4=0 next cycle, pointer reset. With req_1 and req_4 both high after reset, client 1 is granted first.
- req_1 dropped in the first HOLD cycle without done → busy_1 cleared at the next edge; the GAP sequence still runs.
